// File: rtl/mant_mult_iter.sv
// -----------------------------------------------------------------------------
// mant_mult_iter
//
// Iterative unsigned mantissa multiplier for the FP multiply path. Each BUSY
// cycle retires BITS_PER_CYCLE multiplier bits through a shift-add datapath.
// With EARLY_EXIT=1 the operation stops as soon as the remaining multiplier
// bits are all zero. Otherwise latency is fixed at N_ITER cycles.
//
// Ports
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   in_valid         operand pair valid
//   in_ready         operand pair can be accepted this cycle
//   in_multiplicand  unsigned multiplicand, A_WIDTH bits
//   in_multiplier    unsigned multiplier, B_WIDTH bits
//   out_valid        out_product holds a completed result
//   out_ready        downstream consumes the result
//   out_product      full unsigned product, A_WIDTH+B_WIDTH bits
//
// States
//   S_IDLE | waiting for an operand pair
//   S_BUSY | shift-add iterations in progress
//   S_DONE | result presented, held until out_ready
// -----------------------------------------------------------------------------
module mant_mult_iter #(
  parameter int A_WIDTH        = 24,
  parameter int B_WIDTH        = 24,
  parameter int BITS_PER_CYCLE = 4,
  parameter int EARLY_EXIT     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         in_multiplicand,
  input  logic [B_WIDTH-1:0]         in_multiplier,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] out_product
);

  localparam int N_ITER   = (B_WIDTH + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int P_WIDTH  = A_WIDTH + B_WIDTH;
  localparam int BP_WIDTH = N_ITER * BITS_PER_CYCLE;
  localparam int CNT_W    = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [P_WIDTH-1:0]   a_q, a_d;
  logic [BP_WIDTH-1:0]  b_q, b_d;
  logic [P_WIDTH-1:0]   acc_q, acc_d;
  logic [P_WIDTH-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [P_WIDTH-1:0]   partial;
  logic [P_WIDTH-1:0]   acc_sum;
  logic [BP_WIDTH-1:0]  b_shift;
  logic                 last_iter;
  logic                 accept;

  // Partial product for the current chunk of multiplier bits.
  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_q[j]) begin
        partial = partial + (a_q << j);
      end
    end
  end

  assign acc_sum = acc_q + partial;
  assign b_shift = b_q >> BITS_PER_CYCLE;

  // Early exit looks at the multiplier after this cycle's shift, so the
  // iteration that consumes the top nonzero chunk is the last one.
  assign last_iter = (cnt_q == LAST_CNT) ||
                     ((EARLY_EXIT != 0) && (b_shift == '0));

  assign in_ready = !rst && ((state_q == S_IDLE) ||
                             ((state_q == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = P_WIDTH'(in_multiplicand);
          b_d     = BP_WIDTH'(in_multiplier);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        acc_d = acc_sum;
        a_d   = a_q << BITS_PER_CYCLE;
        b_d   = b_shift;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          prod_d  = acc_sum;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Result register is left alone here so out_product only moves on
        // entry to DONE, even across a back-to-back accept.
        if (out_ready) begin
          if (in_valid) begin
            a_d     = P_WIDTH'(in_multiplicand);
            b_d     = BP_WIDTH'(in_multiplier);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = (state_q == S_DONE);
  assign out_product = prod_q;

endmodule

// File: tb/tb_mant_mult_iter.sv
module tb_mant_mult_iter;

  localparam int N_RAND    = 1000;
  localparam int CYC_LIMIT = 50000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_r = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Latency from the rules: fixed N_ITER, or index of the top nonzero chunk + 1.
  function automatic int model_lat(logic [23:0] b, int bpc, bit ee);
    int n_iter;
    int msb;
    n_iter = (24 + bpc - 1) / bpc;
    if (!ee) return n_iter;
    if (b == 24'd0) return 1;
    msb = 0;
    for (int i = 0; i < 24; i++) if (b[i]) msb = i;
    return msb / bpc + 1;
  endfunction

  function automatic logic [23:0] rand_op();
    logic [23:0] v;
    v = 24'($urandom);
    case ($urandom_range(0, 7))
      0: v = v >> $urandom_range(0, 23);
      1: v = 24'hFFFFFF;
      2: v = 24'(1) << $urandom_range(0, 23);
      3: v = 24'd0;
      4: v = v >> $urandom_range(12, 23);
      default: ;
    endcase
    return v;
  endfunction

  // Directed DUTs: 0 = defaults, 1 = fixed latency, 2 = 5 bits per cycle
  logic [2:0]  d_iv, d_ir, d_ov, d_ordy;
  logic [23:0] d_ma [3];
  logic [23:0] d_mb [3];
  logic [47:0] d_op [3];

  mant_mult_iter #(.A_WIDTH(24), .B_WIDTH(24), .BITS_PER_CYCLE(4), .EARLY_EXIT(1)) u_def (
    .clk(clk), .rst(rst_d), .in_valid(d_iv[0]), .in_ready(d_ir[0]),
    .in_multiplicand(d_ma[0]), .in_multiplier(d_mb[0]),
    .out_valid(d_ov[0]), .out_ready(d_ordy[0]), .out_product(d_op[0]));

  mant_mult_iter #(.A_WIDTH(24), .B_WIDTH(24), .BITS_PER_CYCLE(4), .EARLY_EXIT(0)) u_fix (
    .clk(clk), .rst(rst_d), .in_valid(d_iv[1]), .in_ready(d_ir[1]),
    .in_multiplicand(d_ma[1]), .in_multiplier(d_mb[1]),
    .out_valid(d_ov[1]), .out_ready(d_ordy[1]), .out_product(d_op[1]));

  mant_mult_iter #(.A_WIDTH(24), .B_WIDTH(24), .BITS_PER_CYCLE(5), .EARLY_EXIT(1)) u_b5 (
    .clk(clk), .rst(rst_d), .in_valid(d_iv[2]), .in_ready(d_ir[2]),
    .in_multiplicand(d_ma[2]), .in_multiplier(d_mb[2]),
    .out_valid(d_ov[2]), .out_ready(d_ordy[2]), .out_product(d_op[2]));

  // Randomized DUTs: bits per cycle {1,3,4,8,24} x early exit {0,1}
  logic [9:0] rdone;

  for (genvar g = 0; g < 10; g++) begin : g_rand
    localparam int BPC = (g % 5 == 0) ? 1 : (g % 5 == 1) ? 3 : (g % 5 == 2) ? 4 :
                         (g % 5 == 3) ? 8 : 24;
    localparam int EE  = (g >= 5) ? 1 : 0;

    logic        iv = 1'b0, ordy = 1'b0;
    logic        ir, ov;
    logic [23:0] ma = '0, mb = '0;
    logic [47:0] op;
    bit          done_f = 1'b0;

    mant_mult_iter #(.A_WIDTH(24), .B_WIDTH(24), .BITS_PER_CYCLE(BPC), .EARLY_EXIT(EE)) u_dut (
      .clk(clk), .rst(rst_r), .in_valid(iv), .in_ready(ir),
      .in_multiplicand(ma), .in_multiplier(mb),
      .out_valid(ov), .out_ready(ordy), .out_product(op));

    assign rdone[g] = done_f;

    initial begin
      int          ops;
      int          acc_cyc;
      int          lat;
      bit          outst;
      bit          exp_ov;
      bit          exp_ir;
      logic [47:0] ep;
      ops = 0; acc_cyc = 0; lat = 0; outst = 1'b0; ep = '0;
      wait (!rst_r);
      while (ops < N_RAND && cyc < CYC_LIMIT) begin
        @(negedge clk);
        exp_ov = outst && ((cyc - acc_cyc) >= lat);
        chk("rnd_out_valid", 64'(ov), 64'(exp_ov));
        if (ov && exp_ov) chk("rnd_product", 64'(op), 64'(ep));
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
        ma   = rand_op();
        mb   = rand_op();
        #1;
        exp_ir = !outst || (exp_ov && ordy);
        chk("rnd_in_ready", 64'(ir), 64'(exp_ir));
        if (exp_ov && ordy) begin
          outst = 1'b0;
          ops++;
        end
        if (iv && exp_ir) begin
          outst   = 1'b1;
          ep      = 48'(ma) * 48'(mb);
          lat     = model_lat(mb, BPC, EE != 0);
          acc_cyc = cyc + 1;
        end
      end
      chk("rnd_ops_completed", 64'(ops), 64'(N_RAND));
      iv     = 1'b0;
      ordy   = 1'b1;
      done_f = 1'b1;
    end
  end

  // Drive one operand pair with out_ready high; return product and latency.
  task automatic run_vec(input int s, input logic [23:0] a, input logic [23:0] b,
                         output logic [47:0] prod, output int lat);
    @(negedge clk);
    d_ma[s]   = a;
    d_mb[s]   = b;
    d_iv[s]   = 1'b1;
    d_ordy[s] = 1'b1;
    #1 chk("vec_in_ready", 64'(d_ir[s]), 64'd1);
    @(posedge clk);
    #1 d_iv[s] = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (d_ov[s]) break;
    end
    prod = d_op[s];
  endtask

  typedef struct {
    int          sel;
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] prod;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [47:0] p;
    int          l;

    vecs[0] = '{0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 6};
    vecs[1] = '{0, 24'h800000, 24'h000001, 48'h000000800000, 1};
    vecs[2] = '{1, 24'h800000, 24'h000001, 48'h000000800000, 6};
    vecs[3] = '{2, 24'hC00000, 24'h800000, 48'h600000000000, 5};
    vecs[4] = '{0, 24'h000123, 24'h000000, 48'h000000000000, 1};
    vecs[5] = '{0, 24'h000000, 24'hFFFFFF, 48'h000000000000, 6};
    vecs[6] = '{0, 24'hABCDEF, 24'h000010, 48'h00000ABCDEF0, 2};
    vecs[7] = '{1, 24'h000003, 24'h000005, 48'h00000000000F, 6};
    vecs[8] = '{2, 24'hFFFFFF, 24'h00001F, 48'h00001EFFFFE1, 1};
    vecs[9] = '{2, 24'hFFFFFF, 24'h000020, 48'h00001FFFFFE0, 2};

    d_iv   = '0;
    d_ordy = '0;
    for (int i = 0; i < 3; i++) begin
      d_ma[i] = '0;
      d_mb[i] = '0;
    end
    rst_d = 1'b1;
    rst_r = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(d_ir[0]), 64'd0);
    chk("rst_out_valid", 64'(d_ov[0]), 64'd0);
    chk("rst_out_product", 64'(d_op[0]), 64'd0);
    rst_d = 1'b0;
    rst_r = 1'b0;
    #1 chk("release_in_ready", 64'(d_ir[0]), 64'd1);

    for (int v = 0; v < 10; v++) begin
      run_vec(vecs[v].sel, vecs[v].a, vecs[v].b, p, l);
      chk("vec_product", 64'(p), 64'(vecs[v].prod));
      chk("vec_latency", 64'(l), 64'(vecs[v].lat));
      @(posedge clk);
      #1 chk("vec_valid_pulse", 64'(d_ov[vecs[v].sel]), 64'd0);
    end

    // Backpressure in DONE, then back-to-back accept on release
    @(negedge clk);
    d_ma[0] = 24'h000100; d_mb[0] = 24'h000003; d_iv[0] = 1'b1; d_ordy[0] = 1'b0;
    @(posedge clk);
    #1 d_iv[0] = 1'b0;
    l = 0;
    while (l < 40 && !d_ov[0]) begin
      @(posedge clk);
      #1 l++;
    end
    chk("bp_latency", 64'(l), 64'd1);
    chk("bp_product", 64'(d_op[0]), 48'h300);
    d_iv[0] = 1'b1; d_ma[0] = 24'h00FFFF; d_mb[0] = 24'h00FFFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_product", 64'(d_op[0]), 48'h300);
      chk("bp_hold_valid", 64'(d_ov[0]), 64'd1);
      chk("bp_in_ready_low", 64'(d_ir[0]), 64'd0);
    end
    @(negedge clk);
    d_ma[0] = 24'h000003; d_mb[0] = 24'h000005; d_iv[0] = 1'b1; d_ordy[0] = 1'b1;
    #1 chk("b2b_in_ready", 64'(d_ir[0]), 64'd1);
    @(posedge clk);
    #1 d_iv[0] = 1'b0;
    chk("b2b_valid_drop", 64'(d_ov[0]), 64'd0);
    chk("b2b_product_held", 64'(d_op[0]), 48'h300);
    l = 0;
    while (l < 40 && !d_ov[0]) begin
      @(posedge clk);
      #1 l++;
    end
    chk("b2b_latency", 64'(l), 64'd1);
    chk("b2b_product", 64'(d_op[0]), 48'h00000000000F);
    @(posedge clk);
    #1;

    // Reset on the third BUSY cycle discards the operation
    @(negedge clk);
    d_ma[0] = 24'hABCDEF; d_mb[0] = 24'h123456; d_iv[0] = 1'b1; d_ordy[0] = 1'b1;
    @(posedge clk);
    #1 d_iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_d = 1'b1;
    #1 chk("mid_rst_in_ready", 64'(d_ir[0]), 64'd0);
    @(posedge clk);
    #1 rst_d = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(d_ov[0]), 64'd0);
    chk("mid_rst_product", 64'(d_op[0]), 64'd0);
    chk("mid_rst_in_ready_after", 64'(d_ir[0]), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 chk("mid_rst_no_output", 64'(d_ov[0]), 64'd0);
    end
    run_vec(0, 24'h000002, 24'h000002, p, l);
    chk("post_rst_product", 64'(p), 48'h000000000004);
    chk("post_rst_latency", 64'(l), 64'd1);

    l = 0;
    while (rdone != 10'h3FF && l < 60000) begin
      @(posedge clk);
      l++;
    end
    chk("rnd_all_finished", 64'(rdone), 64'h3FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
